// File: rtl/dispatch_queue_if.sv
// rtl/dispatch_queue_if.sv - upstream, commit-req and commit-rsp handshake bundle for dispatch_queue
interface dispatch_queue_if #(
    parameter int DW = 32
);
    logic          in_vaild;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          req_vaild;
    logic          req_ready;
    logic [DW-1:0] r_out;
    logic          rsp_vaild;
    logic          rsp_ready;

    modport master (
        output in_vaild, in_data, req_ready, rsp_vaild,
        input  in_ready, req_vaild, r_out, rsp_ready
    );

    modport slave (
        input  in_vaild, in_data, req_ready, rsp_vaild,
        output in_ready, req_vaild, r_out, rsp_ready
    );
endinterface

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - credit-throttled in-order dispatch FIFO ahead of commit (optional DISPATCH_BYPASS_EN)
module dispatch_queue #(
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int MAX_OUT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    dispatch_queue_if.slave     bus,
    output logic [AW:0]         fill,
    output logic [2:0]          outstanding,
    output logic                err_rsp
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          credit_ok;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          fifo_wr;
    logic          fifo_rd;
    logic          rsp_fire;

    assign full      = fill[AW];
    assign empty     = (fill == '0);
    assign credit_ok = (outstanding < 3'(MAX_OUT));

    // Handshake outputs are held low for the whole reset cycle, so nothing is
    // accepted or issued from state that is about to be discarded.
    assign bus.in_ready  = !full && !flush && !reset;
    assign bus.rsp_ready = !reset;

`ifdef DISPATCH_BYPASS_EN
    assign bypass = empty && credit_ok && !flush && !reset;
`else
    assign bypass = 1'b0;
`endif

    assign bus.req_vaild = bypass ? bus.in_vaild
                                  : (!empty && credit_ok && !flush && !reset);
    assign bus.r_out     = bypass ? bus.in_data : mem[rd_ptr];

    assign push     = bus.in_vaild && bus.in_ready;
    assign pop      = bus.req_vaild && bus.req_ready;
    // A bypassed word taken by commit in the same cycle never touches the FIFO.
    assign fifo_wr  = push && !(bypass && bus.req_ready);
    assign fifo_rd  = pop && !bypass;
    assign rsp_fire = bus.rsp_vaild && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (fifo_wr) begin
                mem[wr_ptr] <= bus.in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // Flush leaves the credit count alone: commit still answers words already issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
            err_rsp     <= 1'b0;
        end else if (pop && !rsp_fire) begin
            outstanding <= outstanding + 1'b1;
        end else if (rsp_fire && !pop) begin
            if (outstanding == '0) begin
                err_rsp <= 1'b1;
            end else begin
                outstanding <= outstanding - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - vector table plus scoreboard bench for dispatch_queue
module tb_dispatch_queue;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [2:0] fill;
    logic [2:0] outstanding;
    logic       err_rsp;

    int checks;
    int failures;

    logic [31:0] sb[$];

    typedef struct {
        logic        iv;
        logic [31:0] data;
        logic        rr;
        logic        rv;
        logic        e_in_ready;
        logic        e_req_vaild;
        logic [2:0]  e_fill;
        logic [2:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    dispatch_queue_if #(.DW(32)) dq ();

    dispatch_queue #(.DW(32), .DEPTH(4), .AW(2), .MAX_OUT(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .bus         (dq),
        .fill        (fill),
        .outstanding (outstanding),
        .err_rsp     (err_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task add(input logic iv, input logic [31:0] data, input logic rr, input logic rv,
             input logic eir, input logic erv, input logic [2:0] ef, input logic [2:0] eo,
             input logic ee);
        vec_t v;
        v.iv = iv; v.data = data; v.rr = rr; v.rv = rv;
        v.e_in_ready = eir; v.e_req_vaild = erv; v.e_fill = ef; v.e_out = eo; v.e_err = ee;
        vecs.push_back(v);
    endtask

    task drive(input logic iv, input logic [31:0] data, input logic rr, input logic rv,
               input logic fl, input logic rst);
        @(posedge clk);
        #1;
        dq.in_vaild  = iv;
        dq.in_data   = data;
        dq.req_ready = rr;
        dq.rsp_vaild = rv;
        flush        = fl;
        reset        = rst;
        @(negedge clk);
    endtask

    // Scoreboard: accepted words queue up, every issue must match the oldest one.
    always @(negedge clk) begin
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (dq.in_vaild && dq.in_ready) sb.push_back(dq.in_data);
            if (dq.req_vaild && dq.req_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL r_out_order actual=%h required=<no word pending>", dq.r_out);
                end else begin
                    chk("r_out_order", dq.r_out, sb.pop_front());
                end
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        flush = 1'b0;
        dq.in_vaild = 1'b0;
        dq.in_data = '0;
        dq.req_ready = 1'b0;
        dq.rsp_vaild = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", dq.in_ready, 0);
        chk("rst_rsp_ready", dq.rsp_ready, 0);
        chk("rst_req_vaild", dq.req_vaild, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("post_rst_fill", fill, 0);
        chk("post_rst_out", outstanding, 0);
        chk("post_rst_err", err_rsp, 0);
        chk("post_rst_r_out", dq.r_out, 0);
        chk("post_rst_in_ready", dq.in_ready, 1);
        chk("post_rst_rsp_ready", dq.rsp_ready, 1);

`ifndef DISPATCH_BYPASS_EN
        add(1, 32'h44C7D916, 1, 0,  1, 0, 0, 0, 0);
        add(0, 32'h0,        1, 0,  1, 1, 1, 0, 0);
        add(0, 32'h0,        0, 0,  1, 0, 0, 1, 0);
        add(0, 32'h0,        0, 1,  1, 0, 0, 1, 0);
        add(1, 32'h4342298A, 0, 0,  1, 0, 0, 0, 0);
        add(1, 32'h3F653322, 0, 0,  1, 1, 1, 0, 0);
        add(1, 32'h56C87D33, 0, 0,  1, 1, 2, 0, 0);
        add(1, 32'h3B7D36FD, 0, 0,  1, 1, 3, 0, 0);
        add(1, 32'h11111111, 0, 0,  0, 1, 4, 0, 0);
        add(1, 32'h11111111, 1, 0,  0, 1, 4, 0, 0);
        add(1, 32'h11111111, 1, 0,  1, 1, 3, 1, 0);
        add(0, 32'h0,        1, 0,  1, 0, 3, 2, 0);
        add(0, 32'h0,        1, 1,  1, 0, 3, 2, 0);
        add(0, 32'h0,        1, 0,  1, 1, 3, 1, 0);
        add(0, 32'h0,        1, 1,  1, 0, 2, 2, 0);
        add(0, 32'h0,        1, 1,  1, 1, 2, 1, 0);
        add(0, 32'h0,        1, 0,  1, 1, 1, 1, 0);
        add(0, 32'h0,        0, 1,  1, 0, 0, 2, 0);
        add(0, 32'h0,        0, 1,  1, 0, 0, 1, 0);
        add(0, 32'h0,        0, 0,  1, 0, 0, 0, 0);
        add(0, 32'h0,        0, 1,  1, 0, 0, 0, 0);
        add(0, 32'h0,        0, 0,  1, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].data, vecs[i].rr, vecs[i].rv, 0, 0);
            chk($sformatf("v%0d_in_ready", i), dq.in_ready, vecs[i].e_in_ready);
            chk($sformatf("v%0d_req_vaild", i), dq.req_vaild, vecs[i].e_req_vaild);
            chk($sformatf("v%0d_fill", i), fill, vecs[i].e_fill);
            chk($sformatf("v%0d_outstanding", i), outstanding, vecs[i].e_out);
            chk($sformatf("v%0d_err_rsp", i), err_rsp, vecs[i].e_err);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("err_sticky", err_rsp, 1);
`else
        drive(1, 32'h01AAA75C, 1, 0, 0, 0);
        chk("byp_req_vaild", dq.req_vaild, 1);
        chk("byp_r_out", dq.r_out, 32'h01AAA75C);
        drive(0, 0, 0, 0, 0, 0);
        chk("byp_fill", fill, 0);
        chk("byp_out", outstanding, 1);
        drive(1, 32'h5A5A0001, 0, 0, 0, 0);
        chk("byp_stall_req_vaild", dq.req_vaild, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("byp_stall_fill", fill, 1);
        chk("byp_stall_r_out", dq.r_out, 32'h5A5A0001);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("byp_drain_fill", fill, 0);
        chk("byp_drain_out", outstanding, 2);
`endif

        drive(0, 0, 0, 0, 0, 1);
        chk("rst2_req_vaild", dq.req_vaild, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rst2_err", err_rsp, 0);
        chk("rst2_out", outstanding, 0);

        drive(1, 32'h0A0A0A0A, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(1, 32'h0B0B0B0B, 0, 0, 0, 0);
        drive(1, 32'h0C0C0C0C, 0, 0, 0, 0);
        drive(1, 32'h0D0D0D0D, 0, 0, 0, 0);
        drive(1, 32'h0E0E0E0E, 1, 0, 1, 0);
        chk("flush_in_ready", dq.in_ready, 0);
        chk("flush_req_vaild", dq.req_vaild, 0);
        chk("flush_fill_before", fill, 3);
        drive(0, 0, 1, 0, 0, 0);
        chk("flush_fill_after", fill, 0);
        chk("flush_req_vaild_after", dq.req_vaild, 0);
        chk("flush_out_kept", outstanding, 1);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("flush_rsp_out", outstanding, 0);
        chk("flush_rsp_err", err_rsp, 0);

        drive(1, 32'h0F0F0F0F, 0, 0, 0, 0);
        drive(1, 32'h10101010, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 1);
        chk("midrst_req_vaild", dq.req_vaild, 0);
        chk("midrst_in_ready", dq.in_ready, 0);
        drive(0, 0, 1, 0, 0, 0);
        chk("midrst_fill", fill, 0);
        chk("midrst_out", outstanding, 0);
        chk("midrst_req_vaild_after", dq.req_vaild, 0);

        drive(0, 0, 0, 0, 0, 0);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
